// File: rtl/mips8_pkg.sv
// Shared types and field positions for the byte-serial instruction fetch unit.
package mips8_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } fetch_state_t;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/instr_fetch_if.sv
// Byte-wide memory read port between the fetch unit (master) and memory (slave).
interface instr_fetch_if #(
   parameter int ADDR_W = 8
);

   logic              mem_read;
   logic [ADDR_W-1:0] mem_adr;
   logic [7:0]        mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_read,
      output mem_adr,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_read,
      input  mem_adr,
      output mem_rdata,
      output mem_ready
   );

endinterface

// File: rtl/fetch_timer.sv
// Per-byte wait counter; expired_o flags the enabled cycle whose increment reaches TIMEOUT.
module fetch_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   logic [7:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 8'd1;
      end
   end

   // Raised in the same cycle as the TIMEOUT-th wait so the FSM leaves REQ on that edge.
   assign expired_o = enable_i && !clear_i && (count_q == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetches one 32-bit little-endian instruction as four byte reads with per-byte timeout and abort.
module instr_fetch
   import mips8_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] pc,
   instr_fetch_if.master     mem,
   output logic [31:0]       instr,
   output logic [5:0]        op,
   output logic [5:0]        funct,
   output logic              instr_valid,
   output logic              busy,
   output logic              fetch_err
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       instr_q, instr_d;
   logic              timer_clear, timer_en, timer_expired;

   fetch_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (timer_clear),
      .enable_i  (timer_en),
      .expired_o (timer_expired)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      idx_d        = idx_q;
      instr_d      = instr_q;
      timer_clear  = 1'b0;
      timer_en     = 1'b0;
      mem.mem_read = 1'b0;
      busy         = 1'b0;
      instr_valid  = 1'b0;
      fetch_err    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d     = REQ;
               base_d      = pc;
               idx_d       = 2'd0;
               timer_clear = 1'b1;
            end
         end
         REQ: begin
            mem.mem_read = 1'b1;
            busy         = 1'b1;
            // Abort wins over a byte arriving in the same cycle.
            if (abort) begin
               state_d = IDLE;
            end else if (mem.mem_ready) begin
               instr_d[{idx_q, 3'b000} +: 8] = mem.mem_rdata;
               timer_clear                   = 1'b1;
               if (idx_q == 2'd3) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end else begin
               timer_en = 1'b1;
               if (timer_expired) begin
                  state_d = ERR;
               end
            end
         end
         DONE: begin
            instr_valid = 1'b1;
            state_d     = IDLE;
         end
         ERR: begin
            fetch_err = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem.mem_adr = base_q + ADDR_W'(idx_q);
   assign instr       = instr_q;
   assign op          = instr_q[OP_MSB:OP_LSB];
   assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];

   // NOTE: non-blocking assignments make every flop load from pre-edge values, whatever the order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         base_q  <= '0;
         idx_q   <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         instr_q <= instr_d;
      end
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles per byte before error; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request fetch of one 32-bit instruction at pc.
REQ-006 abort  input  1  cancel any fetch in progress.
REQ-007 pc  input  ADDR_W  byte address of instruction; sampled only on accepted start.
REQ-008 mem_read  output  1  byte read request to memory.
REQ-009 mem_adr  output  ADDR_W  byte address of current read.
REQ-010 mem_rdata  input  8  read data, valid when mem_ready=1.
REQ-011 mem_ready  input  1  memory acknowledge for the current byte.
REQ-012 instr  output  32  assembled instruction register.
REQ-013 op  output  6  instr[31:26], combinational from instr, feeds controller op.
REQ-014 funct  output  6  instr[5:0], combinational from instr, feeds controller funct.
REQ-015 instr_valid  output  1  one-cycle pulse: instr complete.
REQ-016 busy  output  1  high while a fetch is in progress.
REQ-017 fetch_err  output  1  one-cycle pulse: byte timeout.

Function
REQ-018 FSM states: IDLE, REQ, DONE, ERR.
REQ-019 IDLE: start=1 and abort=0 -> latch pc as base, clear byte index and wait counter, go REQ; start while not IDLE is ignored.
REQ-020 REQ: mem_read=1, mem_adr=(base+idx) mod 2^ADDR_W, busy=1.
REQ-021 REQ with mem_ready=1: write mem_rdata into instr[8*idx+7:8*idx] (little-endian), clear wait counter; idx=3 -> DONE, else idx+1 and stay in REQ.
REQ-022 REQ with mem_ready=0: wait counter +1; counter reaching TIMEOUT -> ERR.
REQ-023 DONE: instr_valid=1 for one cycle, busy=0, mem_read=0; next state IDLE.
REQ-024 ERR: fetch_err=1 for one cycle, busy=0; instr keeps already-written bytes; next state IDLE.
REQ-025 abort=1 in any state -> IDLE next cycle; mem_read=0 that next cycle; no instr_valid or fetch_err pulse; abort overrides mem_ready and start in the same cycle.
REQ-026 Minimum latency with mem_ready tied high: start at cycle N -> instr_valid at cycle N+5.
REQ-027 Bytes not yet written in the current fetch keep their previous value; instr changes only on a captured byte or reset.
REQ-028 mem_ready outside REQ is ignored.

Reset
REQ-029 reset=1 -> state IDLE, idx=0, wait counter=0, base=0, instr=0, mem_adr=0, mem_read=0, busy=0, instr_valid=0, fetch_err=0 after the next edge.
REQ-030 Reset overrides all inputs, including during a fetch in progress; no pulse is emitted for the interrupted fetch.

Structure
REQ-031 Package mips8_pkg SHALL hold the fetch_state_t enum and the constants OP_MSB=31, OP_LSB=26, FUNCT_MSB=5 and FUNCT_LSB=0.
REQ-032 The wait counter is a sub-module, fetch_timer, with clear, enable and an expired output at TIMEOUT; all other logic stays in instr_fetch.

Verification
REQ-033 Case 1: pc=0x10, mem_ready high, bytes 0x20,0x10,0x08,0x8C -> addresses 0x10..0x13, instr=0x8C081020, op=0x23, funct=0x20, instr_valid at N+5.
REQ-034 Case 2: pc=0xFE -> mem_adr sequence 0xFE,0xFF,0x00,0x01.
REQ-035 Case 3: mem_ready withheld for 3 cycles on byte 2 -> mem_adr held at pc+2; instr_valid delayed by 3 cycles; no fetch_err.
REQ-036 Case 4: TIMEOUT=4, mem_ready never asserted on byte 1 -> fetch_err pulse after 4 wait cycles; instr[7:0] updated, instr[31:8] unchanged; busy=0.
REQ-037 Case 5: abort during byte 2 -> IDLE next cycle, mem_read=0, no pulses; a subsequent start fetches normally.
REQ-038 Case 6: reset asserted mid-fetch, together with start -> all outputs at reset values; start ignored that cycle.
